mem_stage: RTL and testbench

Memory-access stage of the five-stage RV32I pipeline. It consumes the EXE/MEM registers produced by the execute stage, performs loads and stores over a simple req/ack data-memory bus, and drives the MEM/WB pipeline registers. It sign- or zero-extends and lane-aligns load data, generates byte enables, stalls the pipeline while the bus is busy, and flags misaligned or timed-out accesses.

---
 rtl/mem_stage.sv | 177 +++++++++++++++++
 tb/tb_mem_stage.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage of the RV32I pipeline: issues loads/stores on a
// req/ack data bus, aligns load data, and drives the MEM/WB registers.
module mem_stage #(
    parameter int XLEN        = 32,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_mem,
    input  logic [XLEN-1:0] alu_mem,
    input  logic [XLEN-1:0] rs2_mem,
    input  logic [XLEN-1:0] instr_mem,
    input  logic [4:0]      rd_addr_mem,
    output logic [XLEN-1:0] forward_mem,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            stall_mem,
    output logic [XLEN-1:0] pc_wb,
    output logic [XLEN-1:0] instr_wb,
    output logic [XLEN-1:0] wb_data_wb,
    output logic [4:0]      rd_addr_wb,
    output logic            valid_wb,
    output logic            misalign_exc,
    output logic            bus_err
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [1:0]      lane;
    logic            is_load, is_store, is_bubble, mem_op;
    logic            f3_legal, aligned, access_ok, exc;
    logic            at_limit, abort;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] load_val;

    assign opcode    = instr_mem[6:0];
    assign funct3    = instr_mem[14:12];
    assign lane      = alu_mem[1:0];
    assign is_load   = (opcode == 7'b0000011);
    assign is_store  = (opcode == 7'b0100011);
    assign is_bubble = (instr_mem == '0);
    assign mem_op    = is_load | is_store;

    assign forward_mem = alu_mem;
    assign dmem_addr   = {alu_mem[XLEN-1:2], 2'b00};

    // Legality of funct3 and address alignment for the decoded access size
    always_comb begin
        f3_legal = 1'b0;
        aligned  = 1'b0;
        if (is_load)
            f3_legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        else
            f3_legal = (funct3 < 3'b011);
        case (funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~lane[0];
            2'b10:   aligned = (lane == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    assign access_ok = mem_op & f3_legal & aligned;
    assign exc       = mem_op & ~access_ok;

    // Bus handshake: EXE/MEM is held stable during WAIT, so req is simply
    // the legal-access decode. In IDLE cnt is 0, so a timeout of 1 aborts
    // in the very first request cycle.
    assign at_limit  = (state_q == S_WAIT) ? (cnt_q == CNT_LAST) : (ACK_TIMEOUT == 1);
    assign dmem_req  = ~rst & access_ok;
    assign dmem_we   = dmem_req & is_store;
    assign abort     = dmem_req & ~dmem_ack & at_limit;
    assign stall_mem = dmem_req & ~dmem_ack & ~abort;

    // Byte enables and lane-replicated store data
    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = rs2_mem;
        case (funct3[1:0])
            2'b00: begin
                dmem_be    = 4'b0001 << lane;
                dmem_wdata = {(XLEN/8){rs2_mem[7:0]}};
            end
            2'b01: begin
                dmem_be    = lane[1] ? 4'b1100 : 4'b0011;
                dmem_wdata = {(XLEN/16){rs2_mem[15:0]}};
            end
            default: begin
                dmem_be    = 4'b1111;
                dmem_wdata = rs2_mem;
            end
        endcase
    end

    assign byte_sel = dmem_rdata[{lane, 3'b000} +: 8];
    assign half_sel = dmem_rdata[{lane[1], 4'b0000} +: 16];

    // Load data extraction with sign/zero extension
    always_comb begin
        load_val = dmem_rdata;
        case (funct3)
            3'b000:  load_val = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b100:  load_val = {{(XLEN-8){1'b0}}, byte_sel};
            3'b001:  load_val = {{(XLEN-16){half_sel[15]}}, half_sel};
            3'b101:  load_val = {{(XLEN-16){1'b0}}, half_sel};
            default: load_val = dmem_rdata;
        endcase
    end

    // Next-state: stay in WAIT counting cycles until ack or abort
    always_comb begin
        state_d = S_IDLE;
        cnt_d   = '0;
        if (dmem_req && !dmem_ack && !abort) begin
            state_d = S_WAIT;
            cnt_d   = cnt_q + 1'b1;
        end
    end

    // State and wait-counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // MEM/WB registers and exception pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_wb        <= '0;
            instr_wb     <= '0;
            wb_data_wb   <= '0;
            rd_addr_wb   <= '0;
            valid_wb     <= 1'b0;
            misalign_exc <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            misalign_exc <= exc;
            bus_err      <= abort;
            if (stall_mem || exc || abort || is_bubble) begin
                pc_wb      <= '0;
                instr_wb   <= '0;
                wb_data_wb <= '0;
                rd_addr_wb <= '0;
                valid_wb   <= 1'b0;
            end else begin
                pc_wb      <= pc_mem;
                instr_wb   <= instr_mem;
                wb_data_wb <= is_load ? load_val : alu_mem;
                rd_addr_wb <= is_store ? 5'd0 : rd_addr_mem;
                valid_wb   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage with a behavioural load/store model.
module tb_mem_stage;

    localparam int XLEN = 32;
    localparam int TO   = 4;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;
    localparam logic [6:0] OP_ALUI  = 7'b0010011;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] pc_mem, alu_mem, rs2_mem, instr_mem;
    logic [4:0]      rd_addr_mem;
    logic [XLEN-1:0] forward_mem;
    logic            dmem_req, dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [3:0]      dmem_be;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_ack;
    logic [XLEN-1:0] dmem_rdata;
    logic            stall_mem;
    logic [XLEN-1:0] pc_wb, instr_wb, wb_data_wb;
    logic [4:0]      rd_addr_wb;
    logic            valid_wb, misalign_exc, bus_err;

    int errors = 0;
    int checks = 0;

    mem_stage #(.XLEN(XLEN), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .pc_mem(pc_mem), .alu_mem(alu_mem), .rs2_mem(rs2_mem),
        .instr_mem(instr_mem), .rd_addr_mem(rd_addr_mem),
        .forward_mem(forward_mem),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall_mem(stall_mem),
        .pc_wb(pc_wb), .instr_wb(instr_wb), .wb_data_wb(wb_data_wb),
        .rd_addr_wb(rd_addr_wb), .valid_wb(valid_wb),
        .misalign_exc(misalign_exc), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [16:0] up);
        return {up, f3, rd, op};
    endfunction

    function automatic bit is_legal(input bit ld, input logic [2:0] f3, input logic [1:0] a);
        int size;
        size = int'(f3) % 4;
        if (ld && (f3 == 3 || f3 == 6 || f3 == 7)) return 0;
        if (!ld && f3 >= 3) return 0;
        if (size == 1 && (int'(a) % 2) != 0) return 0;
        if (size == 2 && a != 0) return 0;
        return 1;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [1:0] a);
        int size;
        size = int'(f3) % 4;
        if (size == 0) return 4'(1 << a);
        if (size == 1) return (a >= 2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        int size;
        size = int'(f3) % 4;
        if (size == 0) return (rs2 & 32'hFF) * 32'h0101_0101;
        if (size == 1) return (rs2 & 32'hFFFF) * 32'h0001_0001;
        return rs2;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] rdata);
        int width, sh;
        logic [31:0] v, mask;
        width = (int'(f3) % 4 == 0) ? 8 : (int'(f3) % 4 == 1) ? 16 : 32;
        sh    = (width == 32) ? 0 : (width == 16) ? 16 * (int'(a) / 2) : 8 * int'(a);
        v     = rdata >> sh;
        if (width < 32) begin
            mask = (32'h1 << width) - 32'h1;
            v    = v & mask;
            if (f3 < 4 && v[width-1]) v = v | ~mask;
        end
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        instr_mem = mk(OP_LOAD, 3'b010, 5'd5, 17'h0); alu_mem = 32'h100;
        pc_mem = 32'h10; rs2_mem = '0; rd_addr_mem = 5'd5;
        dmem_ack = 1'b0; dmem_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%0h exp=0", dmem_req); end
            checks++; if (stall_mem !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0h exp=0", stall_mem); end
            @(posedge clk); #1;
        end
        checks++; if (valid_wb !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0h exp=0", valid_wb); end
        checks++; if (pc_wb !== 32'h0 || instr_wb !== 32'h0 || wb_data_wb !== 32'h0)
            begin errors++; $display("FAIL reset_wb got pc=%h instr=%h data=%h exp=0", pc_wb, instr_wb, wb_data_wb); end
        checks++; if (rd_addr_wb !== 5'd0) begin errors++; $display("FAIL reset_rd got=%0d exp=0", rd_addr_wb); end
        checks++; if (misalign_exc !== 1'b0 || bus_err !== 1'b0)
            begin errors++; $display("FAIL reset_exc got mis=%0b berr=%0b exp=0", misalign_exc, bus_err); end
        rst = 1'b0;
        instr_mem = mk(OP_ALU, 3'b000, 5'd7, 17'h0); alu_mem = 32'h1234; pc_mem = 32'h40; rd_addr_mem = 5'd7;
        #1;
        checks++; if (forward_mem !== 32'h1234) begin errors++; $display("FAIL fwd got=%h exp=00001234", forward_mem); end
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL add_req got=%0h exp=0", dmem_req); end
        tick;
        checks++; if (wb_data_wb !== 32'h1234 || valid_wb !== 1'b1 || rd_addr_wb !== 5'd7 || pc_wb !== 32'h40)
            begin errors++; $display("FAIL add_wb got data=%h v=%0b rd=%0d pc=%h exp 00001234/1/7/00000040", wb_data_wb, valid_wb, rd_addr_wb, pc_wb); end
    endtask

    task automatic test_lb;
        instr_mem = mk(OP_LOAD, 3'b000, 5'd3, 17'h0); alu_mem = 32'h103; rd_addr_mem = 5'd3;
        dmem_rdata = 32'h80FF_FF00; dmem_ack = 1'b1;
        #1;
        checks++; if (dmem_req !== 1'b1 || dmem_be !== 4'b1000 || dmem_addr !== 32'h100 || stall_mem !== 1'b0)
            begin errors++; $display("FAIL lb_bus got req=%0b be=%b addr=%h stall=%0b exp 1/1000/00000100/0", dmem_req, dmem_be, dmem_addr, stall_mem); end
        tick;
        checks++; if (wb_data_wb !== 32'hFFFF_FF80 || valid_wb !== 1'b1 || rd_addr_wb !== 5'd3)
            begin errors++; $display("FAIL lb_data got=%h v=%0b rd=%0d exp ffffff80/1/3", wb_data_wb, valid_wb, rd_addr_wb); end
        instr_mem = mk(OP_LOAD, 3'b100, 5'd3, 17'h0);
        tick;
        checks++; if (wb_data_wb !== 32'h0000_0080) begin errors++; $display("FAIL lbu_data got=%h exp=00000080", wb_data_wb); end
        dmem_ack = 1'b0;
    endtask

    task automatic test_sh_wait;
        int stalls;
        stalls = 0;
        instr_mem = mk(OP_STORE, 3'b001, 5'd9, 17'h0); alu_mem = 32'h202;
        rs2_mem = 32'hAAAA_BEEF; rd_addr_mem = 5'd9; pc_mem = 32'h80;
        for (int k = 0; k < 4; k++) begin
            dmem_ack = (k == 3);
            #1;
            if (stall_mem) stalls++;
            checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_be !== 4'b1100 ||
                          dmem_wdata !== 32'hBEEF_BEEF || dmem_addr !== 32'h200)
                begin errors++; $display("FAIL sh_bus c%0d got req=%0b we=%0b be=%b wd=%h addr=%h", k, dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr); end
            tick;
            if (k < 3) begin
                checks++; if (valid_wb !== 1'b0) begin errors++; $display("FAIL sh_stall_bubble c%0d got=%0b exp=0", k, valid_wb); end
            end
        end
        dmem_ack = 1'b0;
        checks++; if (stalls !== 3) begin errors++; $display("FAIL sh_stall_cycles got=%0d exp=3", stalls); end
        checks++; if (valid_wb !== 1'b1 || rd_addr_wb !== 5'd0 || bus_err !== 1'b0)
            begin errors++; $display("FAIL sh_wb got v=%0b rd=%0d berr=%0b exp 1/0/0", valid_wb, rd_addr_wb, bus_err); end
    endtask

    task automatic test_misalign;
        instr_mem = mk(OP_LOAD, 3'b010, 5'd4, 17'h0); alu_mem = 32'h101; rd_addr_mem = 5'd4;
        dmem_ack = 1'b0;
        #1;
        checks++; if (dmem_req !== 1'b0 || stall_mem !== 1'b0)
            begin errors++; $display("FAIL mis_req got req=%0b stall=%0b exp 0/0", dmem_req, stall_mem); end
        tick;
        checks++; if (misalign_exc !== 1'b1 || valid_wb !== 1'b0 || rd_addr_wb !== 5'd0)
            begin errors++; $display("FAIL mis_exc got mis=%0b v=%0b rd=%0d exp 1/0/0", misalign_exc, valid_wb, rd_addr_wb); end
        instr_mem = mk(OP_ALUI, 3'b000, 5'd6, 17'h0); alu_mem = 32'h55; rd_addr_mem = 5'd6;
        tick;
        checks++; if (misalign_exc !== 1'b0 || valid_wb !== 1'b1)
            begin errors++; $display("FAIL mis_pulse got mis=%0b v=%0b exp 0/1", misalign_exc, valid_wb); end
    endtask

    task automatic test_timeout;
        int reqs, stalls;
        bit s;
        reqs = 0; stalls = 0;
        instr_mem = mk(OP_LOAD, 3'b010, 5'd8, 17'h0); alu_mem = 32'h300; rd_addr_mem = 5'd8;
        dmem_ack = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            s = stall_mem;
            if (dmem_req) reqs++;
            if (s) stalls++;
            tick;
            if (!s) break;
        end
        checks++; if (reqs !== TO) begin errors++; $display("FAIL to_req_cycles got=%0d exp=%0d", reqs, TO); end
        checks++; if (stalls !== TO - 1) begin errors++; $display("FAIL to_stall_cycles got=%0d exp=%0d", stalls, TO - 1); end
        checks++; if (bus_err !== 1'b1 || valid_wb !== 1'b0 || rd_addr_wb !== 5'd0)
            begin errors++; $display("FAIL to_wb got berr=%0b v=%0b rd=%0d exp 1/0/0", bus_err, valid_wb, rd_addr_wb); end
        instr_mem = mk(OP_ALU, 3'b000, 5'd2, 17'h0); alu_mem = 32'h99; rd_addr_mem = 5'd2;
        tick;
        checks++; if (bus_err !== 1'b0 || valid_wb !== 1'b1 || wb_data_wb !== 32'h99)
            begin errors++; $display("FAIL to_next got berr=%0b v=%0b data=%h exp 0/1/00000099", bus_err, valid_wb, wb_data_wb); end
    endtask

    task automatic test_reset_mid_wait;
        int reqs;
        bit s;
        instr_mem = mk(OP_LOAD, 3'b010, 5'd5, 17'h0); alu_mem = 32'h400; rd_addr_mem = 5'd5;
        dmem_ack = 1'b0;
        #1;
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rmw_req0 got=%0b exp=1", dmem_req); end
        tick;
        tick;
        rst = 1'b1;
        #1;
        checks++; if (dmem_req !== 1'b0 || stall_mem !== 1'b0)
            begin errors++; $display("FAIL rmw_req_drop got req=%0b stall=%0b exp 0/0", dmem_req, stall_mem); end
        tick;
        rst = 1'b0;
        instr_mem = '0; dmem_ack = 1'b1;
        #1;
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rmw_late_req got=%0b exp=0", dmem_req); end
        tick;
        dmem_ack = 1'b0;
        checks++; if (valid_wb !== 1'b0) begin errors++; $display("FAIL rmw_late_ack got v=%0b exp=0", valid_wb); end
        // counter must restart from zero: a fresh unacked load gets the full timeout
        reqs = 0;
        instr_mem = mk(OP_LOAD, 3'b010, 5'd5, 17'h0); alu_mem = 32'h404;
        for (int k = 0; k < 10; k++) begin
            #1;
            s = stall_mem;
            if (dmem_req) reqs++;
            tick;
            if (!s) break;
        end
        checks++; if (reqs !== TO) begin errors++; $display("FAIL rmw_cnt_restart got=%0d exp=%0d", reqs, TO); end
    endtask

    task automatic test_random;
        int cls, delay, k;
        bit ld, mem, legal, done, aborted, ack_now, exp_stall;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] alu, rs2, pc, rdata, ins;
        logic [31:0] exp_data;
        for (int it = 0; it < 80; it++) begin
            cls   = int'($urandom_range(0, 3));
            f3    = 3'($urandom_range(0, 7));
            rd    = 5'($urandom);
            alu   = $urandom; rs2 = $urandom; pc = $urandom; rdata = $urandom;
            delay = int'($urandom_range(0, 5));
            ld    = (cls == 0);
            mem   = (cls < 2);
            case (cls)
                0:       ins = mk(OP_LOAD, f3, rd, 17'($urandom));
                1:       ins = mk(OP_STORE, f3, rd, 17'($urandom));
                2:       ins = mk(OP_ALUI, f3, rd, 17'($urandom));
                default: ins = 32'h0;
            endcase
            legal   = mem && is_legal(ld, f3, alu[1:0]);
            aborted = legal && (delay >= TO);
            instr_mem = ins; alu_mem = alu; rs2_mem = rs2; pc_mem = pc;
            rd_addr_mem = rd; dmem_rdata = rdata;
            k = 0; done = 0;
            while (!done && k < 10) begin
                ack_now  = legal && (k == delay);
                dmem_ack = ack_now;
                #1;
                exp_stall = legal && !ack_now && (k != TO - 1);
                checks++; if (dmem_req !== legal)
                    begin errors++; $display("FAIL rnd_req it%0d c%0d got=%0b exp=%0b", it, k, dmem_req, legal); end
                checks++; if (stall_mem !== exp_stall)
                    begin errors++; $display("FAIL rnd_stall it%0d c%0d got=%0b exp=%0b", it, k, stall_mem, exp_stall); end
                if (legal && k == 0) begin
                    checks++; if (dmem_be !== exp_be(f3, alu[1:0]) || dmem_addr !== (alu & 32'hFFFF_FFFC) || dmem_we !== !ld)
                        begin errors++; $display("FAIL rnd_bus it%0d got be=%b addr=%h we=%0b exp be=%b addr=%h we=%0b", it, dmem_be, dmem_addr, dmem_we, exp_be(f3, alu[1:0]), alu & 32'hFFFF_FFFC, !ld); end
                    if (!ld) begin
                        checks++; if (dmem_wdata !== exp_wdata(f3, rs2))
                            begin errors++; $display("FAIL rnd_wdata it%0d got=%h exp=%h", it, dmem_wdata, exp_wdata(f3, rs2)); end
                    end
                end
                done = !legal || ack_now || (k == TO - 1);
                tick;
                k++;
                if (!done) begin
                    checks++; if (valid_wb !== 1'b0)
                        begin errors++; $display("FAIL rnd_stall_bubble it%0d got=%0b exp=0", it, valid_wb); end
                end
            end
            dmem_ack = 1'b0;
            checks++; if (misalign_exc !== (mem && !legal) || bus_err !== aborted)
                begin errors++; $display("FAIL rnd_exc it%0d got mis=%0b berr=%0b exp %0b/%0b", it, misalign_exc, bus_err, mem && !legal, aborted); end
            if (cls == 3 || (mem && !legal) || aborted) begin
                checks++; if (valid_wb !== 1'b0 || rd_addr_wb !== 5'd0)
                    begin errors++; $display("FAIL rnd_bubble it%0d got v=%0b rd=%0d exp 0/0", it, valid_wb, rd_addr_wb); end
            end else begin
                checks++; if (valid_wb !== 1'b1 || rd_addr_wb !== ((cls == 1) ? 5'd0 : rd) || pc_wb !== pc || instr_wb !== ins)
                    begin errors++; $display("FAIL rnd_wb it%0d got v=%0b rd=%0d pc=%h ins=%h exp rd=%0d pc=%h ins=%h", it, valid_wb, rd_addr_wb, pc_wb, instr_wb, (cls == 1) ? 5'd0 : rd, pc, ins); end
                if (cls != 1) begin
                    exp_data = ld ? exp_load(f3, alu[1:0], rdata) : alu;
                    checks++; if (wb_data_wb !== exp_data)
                        begin errors++; $display("FAIL rnd_data it%0d f3=%0d a=%0d got=%h exp=%h", it, f3, alu[1:0], wb_data_wb, exp_data); end
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_lb;
        test_sh_wait;
        test_misalign;
        test_timeout;
        test_reset_mid_wait;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
